// File: rtl/updown_counter_if.sv
// -----------------------------------------------------------------------------
// updown_counter_if
//   Control and status bundle for one updown_counter stage.
//   master : drives en/up/load/din/clr and observes q/cr/tc/ovf
//   slave  : the counter itself
//   Signals
//     en   count enable        up   direction (1 = increment)
//     load synchronous load    din  load value (WIDTH)
//     clr  synchronous clear   q    current count (WIDTH)
//     cr   carry/borrow pulse  tc   combinational terminal count
//     ovf  sticky overflow/underflow flag
// -----------------------------------------------------------------------------
interface updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] din;
    logic             clr;
    logic [WIDTH-1:0] q;
    logic             cr;
    logic             tc;
    logic             ovf;

    modport master (
        output en, up, load, din, clr,
        input  q, cr, tc, ovf
    );

    modport slave (
        input  en, up, load, din, clr,
        output q, cr, tc, ovf
    );
endinterface

// File: rtl/updown_counter.sv
// -----------------------------------------------------------------------------
// updown_counter
//   Parametrised modulo 0..TOP up/down counter with enable, synchronous
//   load/clear, wrap or saturate at the limits, a registered carry/borrow
//   pulse, a combinational terminal count for chaining and a sticky
//   overflow flag.
//   Ports
//     clk    rising-edge clock
//     reset  asynchronous active-high reset (q, cr, ovf -> 0)
//     bus    updown_counter_if.slave (en, up, load, din, clr -> q, cr, tc, ovf)
// -----------------------------------------------------------------------------
module updown_counter #(
    parameter int WIDTH = 4,
    parameter int TOP   = 9,
    parameter bit WRAP  = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    updown_counter_if.slave     bus
);

    localparam logic [WIDTH-1:0] TOP_V = WIDTH'(TOP);

    logic [WIDTH-1:0] r_q;
    logic             r_cr;
    logic             r_ovf;

    logic [WIDTH-1:0] w_q_nxt;
    logic             w_cr_nxt;
    logic             w_ovf_nxt;
    logic             w_at_top;
    logic             w_at_zero;

    // >= rather than == so a corrupted q above TOP still heads back into range
    assign w_at_top  = (r_q >= TOP_V);
    assign w_at_zero = (r_q == '0);

    // Priority clr > load > en; idle holds q and drops cr
    always_comb begin
        w_q_nxt   = r_q;
        w_cr_nxt  = 1'b0;
        w_ovf_nxt = r_ovf;
        if (bus.clr) begin
            w_q_nxt   = '0;
            w_ovf_nxt = 1'b0;
        end else if (bus.load) begin
            // Clamp so q can never exceed TOP
            w_q_nxt = (bus.din > TOP_V) ? TOP_V : bus.din;
        end else if (bus.en) begin
            if (bus.up) begin
                if (!w_at_top) begin
                    w_q_nxt = r_q + 1'b1;
                end else begin
                    w_ovf_nxt = 1'b1;
                    if (WRAP) begin
                        w_q_nxt  = '0;
                        w_cr_nxt = 1'b1;
                    end else begin
                        w_q_nxt  = TOP_V;
                    end
                end
            end else begin
                if (!w_at_zero) begin
                    w_q_nxt = r_q - 1'b1;
                end else begin
                    w_ovf_nxt = 1'b1;
                    if (WRAP) begin
                        w_q_nxt  = TOP_V;
                        w_cr_nxt = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q   <= '0;
            r_cr  <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_q   <= w_q_nxt;
            r_cr  <= w_cr_nxt;
            r_ovf <= w_ovf_nxt;
        end
    end

    assign bus.q   = r_q;
    assign bus.cr  = r_cr;
    assign bus.ovf = r_ovf;
    // Ungated by clr/load so the next stage's enable is known before the edge
    assign bus.tc  = bus.en & ((bus.up & (r_q == TOP_V)) | (~bus.up & w_at_zero));

endmodule

// File: tb/tb_updown_counter.sv
module tb_updown_counter;

    logic clk;
    logic reset;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int q;
        int cr;
        int ovf;
    } st_t;

    st_t sb[$];          // expected post-edge state, pushed at drive time
    int  sb_casc[$];     // expected cascade value {high,low} as 0..99
    st_t m_dut, m_sat;   // bench reference state per instance

    updown_counter_if #(.WIDTH(4)) dut_if ();
    updown_counter_if #(.WIDTH(4)) sat_if ();
    updown_counter_if #(.WIDTH(4)) lo_if  ();
    updown_counter_if #(.WIDTH(4)) hi_if  ();

    updown_counter #(.WIDTH(4), .TOP(9), .WRAP(1'b1)) u_dut (.clk(clk), .reset(reset), .bus(dut_if));
    updown_counter #(.WIDTH(4), .TOP(5), .WRAP(1'b0)) u_sat (.clk(clk), .reset(reset), .bus(sat_if));
    updown_counter #(.WIDTH(4), .TOP(9), .WRAP(1'b1)) u_lo  (.clk(clk), .reset(reset), .bus(lo_if));
    updown_counter #(.WIDTH(4), .TOP(9), .WRAP(1'b1)) u_hi  (.clk(clk), .reset(reset), .bus(hi_if));

    // Ripple-free chain: low stage's tc enables the high stage
    assign hi_if.en = lo_if.tc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic st_t model(input st_t s, input int top, input bit wrap,
                                  input bit c, input bit l, input bit e,
                                  input bit u, input int d);
        st_t n;
        n    = s;
        n.cr = 0;
        if (c) begin
            n.q = 0; n.ovf = 0;
        end else if (l) begin
            n.q = (d > top) ? top : d;
        end else if (e) begin
            if (u) begin
                if (s.q < top) n.q = s.q + 1;
                else begin
                    n.ovf = 1;
                    if (wrap) begin n.q = 0; n.cr = 1; end
                end
            end else begin
                if (s.q > 0) n.q = s.q - 1;
                else begin
                    n.ovf = 1;
                    if (wrap) begin n.q = top; n.cr = 1; end
                end
            end
        end
        return n;
    endfunction

    // One clocked step on instance w (0 = wrap TOP=9, 1 = saturate TOP=5)
    task automatic step(input int w, input bit c, input bit l, input bit e,
                        input bit u, input int d);
        st_t cur, nx, ex;
        int  top, gq, gcr, govf, gtc;
        bit  wrap;
        if (w == 0) begin
            cur = m_dut; top = 9; wrap = 1'b1;
            dut_if.clr = c; dut_if.load = l; dut_if.en = e; dut_if.up = u;
            dut_if.din = 4'(d);
        end else begin
            cur = m_sat; top = 5; wrap = 1'b0;
            sat_if.clr = c; sat_if.load = l; sat_if.en = e; sat_if.up = u;
            sat_if.din = 4'(d);
        end
        #1;
        gtc = (w == 0) ? int'(dut_if.tc) : int'(sat_if.tc);
        chk("tc", gtc, int'(e && ((u && cur.q == top) || (!u && cur.q == 0))));
        nx = model(cur, top, wrap, c, l, e, u, d);
        sb.push_back(nx);
        if (w == 0) m_dut = nx; else m_sat = nx;
        @(posedge clk);
        #1;
        ex = sb.pop_front();
        if (w == 0) begin
            gq = int'(dut_if.q); gcr = int'(dut_if.cr); govf = int'(dut_if.ovf);
        end else begin
            gq = int'(sat_if.q); gcr = int'(sat_if.cr); govf = int'(sat_if.ovf);
        end
        chk("q",   gq,   ex.q);
        chk("cr",  gcr,  ex.cr);
        chk("ovf", govf, ex.ovf);
    endtask

    initial begin
        int n, exp_c;
        reset = 1'b1;
        dut_if.clr = 0; dut_if.load = 0; dut_if.en = 0; dut_if.up = 0; dut_if.din = '0;
        sat_if.clr = 0; sat_if.load = 0; sat_if.en = 0; sat_if.up = 0; sat_if.din = '0;
        lo_if.clr  = 0; lo_if.load  = 0; lo_if.en  = 0; lo_if.up  = 1; lo_if.din  = '0;
        hi_if.clr  = 0; hi_if.load  = 0;                 hi_if.up  = 1; hi_if.din  = '0;
        m_dut = '{0, 0, 0};
        m_sat = '{0, 0, 0};
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("rst_q",   int'(dut_if.q),   0);
        chk("rst_cr",  int'(dut_if.cr),  0);
        chk("rst_ovf", int'(dut_if.ovf), 0);
        chk("rst_tc",  int'(dut_if.tc),  0);

        // Up count through the wrap: 1..9,0,1,2
        repeat (12) step(0, 0, 0, 1, 1, 0);
        chk("up_end_q", int'(dut_if.q), 2);

        // Load 3 then count down through the borrow: 2,1,0,9,8
        step(0, 0, 1, 0, 0, 3);
        repeat (5) step(0, 0, 0, 1, 0, 0);
        chk("dn_end_q", int'(dut_if.q), 8);

        // Saturating instance: stops at 5, no cr, ovf once pushed past; then clear
        repeat (8) step(1, 0, 0, 1, 1, 0);
        chk("sat_q", int'(sat_if.q), 5);
        step(1, 1, 0, 1, 1, 0);
        // Saturating down at 0
        step(1, 0, 0, 1, 0, 0);

        // Priority: clr over load over en; load clamps; idle holds
        step(0, 1, 1, 1, 1, 7);
        step(0, 0, 1, 1, 1, 15);
        repeat (3) step(0, 0, 0, 0, 1, 0);

        // Drive to a borrow (q=9, cr=1, ovf=1), then async reset between edges
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        chk("pre_rst_cr", int'(dut_if.cr), 1);
        dut_if.en = 1'b1; dut_if.up = 1'b1;
        reset = 1'b1;
        #2;
        chk("arst_q",   int'(dut_if.q),   0);
        chk("arst_cr",  int'(dut_if.cr),  0);
        chk("arst_ovf", int'(dut_if.ovf), 0);
        #1;
        reset = 1'b0;
        m_dut = '{0, 0, 0};
        m_sat = '{0, 0, 0};
        @(posedge clk);
        #1;
        chk("resume_q", int'(dut_if.q), 1);
        m_dut.q = 1;
        repeat (3) step(0, 0, 0, 1, 1, 0);

        // Two-digit cascade from 00: 100 enabled cycles walk 01..99 then 00
        lo_if.en = 1'b1;
        for (n = 0; n < 100; n++) begin
            sb_casc.push_back((n + 1) % 100);
            @(posedge clk);
            #1;
            exp_c = sb_casc.pop_front();
            chk("casc", int'(hi_if.q) * 10 + int'(lo_if.q), exp_c);
        end
        chk("casc_hi_ovf", int'(hi_if.ovf), 1);
        lo_if.en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
